// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the UART async RX FIFO: owns the read pointer, empty/level/threshold
// flags, and arbitrates pops between single APB reads and a drain-all flush.
//
// state | meaning
// IDLE  | serve APB single-word reads; accept flush requests
// FLUSH | pop one word per cycle until empty, then pulse flush_done
module fifo_rd_ctrl #(
    parameter int ADDRSIZEL = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDRSIZEL:0]   rq2_wptr,
    output logic [ADDRSIZEL:0]   rptr,
    output logic [ADDRSIZEL-1:0] raddr,
    input  logic [7:0]           mem_rdata,
    input  logic                 apb_rd_req,
    output logic                 rd_ack,
    output logic                 rd_err,
    output logic [7:0]           rd_data,
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done,
    input  logic [ADDRSIZEL:0]   rx_thresh,
    output logic                 rempty,
    output logic [ADDRSIZEL:0]   rlevel,
    output logic                 irq_thresh
);

    localparam int PW = ADDRSIZEL + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] rbin, rbin_next, rgray_next, wbin, level_next;
    logic          pop, apb_pop, done_next;

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        apb_pop    = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (apb_rd_req && !rempty) begin
                    pop     = 1'b1;
                    apb_pop = 1'b1;
                end
            end
            FLUSH: begin
                if (!rempty) begin
                    pop = 1'b1;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    assign rbin_next  = rbin + {{ADDRSIZEL{1'b0}}, pop};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign wbin       = gray2bin(rq2_wptr);
    assign level_next = wbin - rbin_next;
    assign raddr      = rbin[ADDRSIZEL-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A reset during FLUSH simply lands here, so no flush_done is produced.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            rlevel     <= '0;
            irq_thresh <= 1'b0;
            rd_data    <= '0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            rptr       <= rgray_next;
            rempty     <= (rgray_next == rq2_wptr);
            rlevel     <= level_next;
            irq_thresh <= (rx_thresh != '0) && (level_next >= rx_thresh);
            if (apb_pop) begin
                rd_data <= mem_rdata;
            end
            rd_ack     <= apb_rd_req;
            rd_err     <= apb_rd_req && !apb_pop;
            flush_busy <= (state_next == FLUSH);
            flush_done <= done_next;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a table of single-cycle vectors followed by
// hand-written flush, reset-during-flush and pointer-wrap sequences.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic [7:0] mem_rdata;
    logic       apb_rd_req;
    logic       rd_ack;
    logic       rd_err;
    logic [7:0] rd_data;
    logic       flush_req;
    logic       flush_busy;
    logic       flush_done;
    logic [4:0] rx_thresh;
    logic       rempty;
    logic [4:0] rlevel;
    logic       irq_thresh;

    int n_vec = 0;
    int n_err = 0;

    fifo_rd_ctrl #(.ADDRSIZEL(4)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rq2_wptr   (rq2_wptr),
        .rptr       (rptr),
        .raddr      (raddr),
        .mem_rdata  (mem_rdata),
        .apb_rd_req (apb_rd_req),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .rd_data    (rd_data),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .rx_thresh  (rx_thresh),
        .rempty     (rempty),
        .rlevel     (rlevel),
        .irq_thresh (irq_thresh)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [4:0] wptr;
        logic [7:0] rdata;
        logic       apb;
        logic       flush;
        logic [4:0] thr;
        logic       ack;
        logic       err;
        logic [7:0] data;
        logic [4:0] rptr;
        logic [3:0] raddr;
        logic       empty;
        logic [4:0] level;
        logic       irq;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vq[$];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] wptr, input logic [7:0] rdata, input logic apb,
                       input logic flush, input logic [4:0] thr, input logic ack, input logic err,
                       input logic [7:0] data, input logic [4:0] rp, input logic [3:0] ra,
                       input logic empty, input logic [4:0] level, input logic irq,
                       input logic busy, input logic done);
        vq.push_back('{wptr, rdata, apb, flush, thr, ack, err, data, rp, ra, empty, level, irq,
                       busy, done});
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        int busy_cnt;
        int cyc;

        // wptr  rdata apb fl thr | ack err data rptr raddr empty level irq busy done
        add(5'd2,  8'h11, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 8'h00, 5'd0, 4'd0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0);
        add(5'd2,  8'hA5, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 8'hA5, 5'd1, 4'd1, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0);
        add(5'd2,  8'h5A, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 8'h5A, 5'd3, 4'd2, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0);
        add(5'd2,  8'h33, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 8'h33, 5'd2, 4'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
        add(5'd2,  8'h44, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 8'h33, 5'd2, 4'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
        add(5'd2,  8'h44, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 8'h33, 5'd2, 4'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
        // flush while empty: one FLUSH cycle, then done; repeat flush_req ignored, APB refused
        add(5'd2,  8'h44, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 8'h33, 5'd2, 4'd3, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0);
        add(5'd2,  8'h44, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 8'h33, 5'd2, 4'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1);
        add(5'd2,  8'h44, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 8'h33, 5'd2, 4'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
        // threshold: level 3 -> 4 raises irq, a pop drops it, thr=0 masks it, boundaries
        add(5'd5,  8'h44, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 8'h33, 5'd2, 4'd3, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0);
        add(5'd4,  8'h44, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 8'h33, 5'd2, 4'd3, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0);
        add(5'd4,  8'h77, 1'b1, 1'b0, 5'd4,  1'b1, 1'b0, 8'h77, 5'd6, 4'd4, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0);
        add(5'd12, 8'h77, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 8'h77, 5'd6, 4'd4, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0);
        add(5'd12, 8'h77, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 8'h77, 5'd6, 4'd4, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0);
        add(5'd12, 8'h77, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 8'h77, 5'd6, 4'd4, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0);
        add(5'd30, 8'h77, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 8'h77, 5'd6, 4'd4, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0);
        add(5'd30, 8'h88, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 8'h88, 5'd7, 4'd5, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);

        // reset with a non-zero write pointer present
        rrst       = 1'b1;
        rq2_wptr   = 5'b00011;
        mem_rdata  = 8'h00;
        apb_rd_req = 1'b0;
        flush_req  = 1'b0;
        rx_thresh  = 5'd0;
        repeat (2) tick();
        chk("rst rempty", 32'(rempty), 32'd1);
        chk("rst rptr", 32'(rptr), 32'd0);
        chk("rst raddr", 32'(raddr), 32'd0);
        chk("rst rlevel", 32'(rlevel), 32'd0);
        chk("rst rd_ack", 32'(rd_ack), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        chk("rst irq", 32'(irq_thresh), 32'd0);
        chk("rst busy", 32'(flush_busy), 32'd0);
        chk("rst done", 32'(flush_done), 32'd0);
        rrst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            rq2_wptr   = vq[i].wptr;
            mem_rdata  = vq[i].rdata;
            apb_rd_req = vq[i].apb;
            flush_req  = vq[i].flush;
            rx_thresh  = vq[i].thr;
            tick();
            chk($sformatf("v%0d rd_ack", i), 32'(rd_ack), 32'(vq[i].ack));
            chk($sformatf("v%0d rd_err", i), 32'(rd_err), 32'(vq[i].err));
            chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vq[i].data));
            chk($sformatf("v%0d rptr", i), 32'(rptr), 32'(vq[i].rptr));
            chk($sformatf("v%0d raddr", i), 32'(raddr), 32'(vq[i].raddr));
            chk($sformatf("v%0d rempty", i), 32'(rempty), 32'(vq[i].empty));
            chk($sformatf("v%0d rlevel", i), 32'(rlevel), 32'(vq[i].level));
            chk($sformatf("v%0d irq", i), 32'(irq_thresh), 32'(vq[i].irq));
            chk($sformatf("v%0d busy", i), 32'(flush_busy), 32'(vq[i].busy));
            chk($sformatf("v%0d done", i), 32'(flush_done), 32'(vq[i].done));
        end
        apb_rd_req = 1'b0;
        flush_req  = 1'b0;
        rx_thresh  = 5'd0;

        // flush of 5 words, APB read arriving with flush_req and again during FLUSH
        rrst     = 1'b1;
        rq2_wptr = 5'd0;
        tick();
        rrst     = 1'b0;
        rq2_wptr = gray(5'd5);
        tick();
        chk("fA level5", 32'(rlevel), 32'd5);
        flush_req  = 1'b1;
        apb_rd_req = 1'b1;
        mem_rdata  = 8'hC3;
        tick();
        flush_req  = 1'b0;
        apb_rd_req = 1'b0;
        chk("fA req ack", 32'(rd_ack), 32'd1);
        chk("fA req err", 32'(rd_err), 32'd1);
        chk("fA req busy", 32'(flush_busy), 32'd1);
        chk("fA req level", 32'(rlevel), 32'd5);
        busy_cnt = 1;
        cyc      = 0;
        while (!flush_done && cyc < 30) begin
            if (cyc == 0) apb_rd_req = 1'b1;
            tick();
            if (cyc == 0) begin
                chk("fA busy ack", 32'(rd_ack), 32'd1);
                chk("fA busy err", 32'(rd_err), 32'd1);
                apb_rd_req = 1'b0;
            end
            if (flush_busy) busy_cnt++;
            cyc++;
        end
        chk("fA done", 32'(flush_done), 32'd1);
        chk("fA busy off", 32'(flush_busy), 32'd0);
        // five pop cycles plus the cycle that observes empty
        chk("fA busy cycles", 32'(busy_cnt), 32'd6);
        chk("fA level", 32'(rlevel), 32'd0);
        chk("fA empty", 32'(rempty), 32'd1);
        chk("fA rptr", 32'(rptr), 32'(gray(5'd5)));
        chk("fA rd_data held", 32'(rd_data), 32'd0);
        tick();
        chk("fA done pulse", 32'(flush_done), 32'd0);

        // plain flush of 5 words, 2 more written mid-flush get drained too
        rq2_wptr = gray(5'd10);
        tick();
        chk("fB level5", 32'(rlevel), 32'd5);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("fB busy", 32'(flush_busy), 32'd1);
        busy_cnt = 1;
        cyc      = 0;
        while (!flush_done && cyc < 30) begin
            if (cyc == 1) rq2_wptr = gray(5'd12);
            tick();
            if (flush_busy) busy_cnt++;
            cyc++;
        end
        chk("fB done", 32'(flush_done), 32'd1);
        chk("fB busy cycles", 32'(busy_cnt), 32'd8);
        chk("fB rptr", 32'(rptr), 32'(gray(5'd12)));
        chk("fB level", 32'(rlevel), 32'd0);
        chk("fB empty", 32'(rempty), 32'd1);

        // reset in the middle of a flush: aborted without flush_done
        rq2_wptr = gray(5'd15);
        tick();
        chk("fC level3", 32'(rlevel), 32'd3);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        chk("fC busy", 32'(flush_busy), 32'd1);
        chk("fC level2", 32'(rlevel), 32'd2);
        rrst = 1'b1;
        tick();
        chk("fC rst busy", 32'(flush_busy), 32'd0);
        chk("fC rst done", 32'(flush_done), 32'd0);
        chk("fC rst empty", 32'(rempty), 32'd1);
        chk("fC rst rptr", 32'(rptr), 32'd0);
        chk("fC rst level", 32'(rlevel), 32'd0);
        rrst     = 1'b0;
        rq2_wptr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fC post done %0d", i), 32'(flush_done), 32'd0);
            chk($sformatf("fC post busy %0d", i), 32'(flush_busy), 32'd0);
        end

        // 40 write/pop pairs through the 32-count pointer wrap, level held at 1
        rq2_wptr = gray(5'd1);
        tick();
        chk("wrap level1", 32'(rlevel), 32'd1);
        chk("wrap empty0", 32'(rempty), 32'd0);
        for (int i = 0; i < 40; i++) begin
            rq2_wptr   = gray(5'(i + 2));
            mem_rdata  = 8'(i + 8'h40);
            apb_rd_req = 1'b1;
            tick();
            chk($sformatf("wrap%0d ack", i), 32'(rd_ack), 32'd1);
            chk($sformatf("wrap%0d err", i), 32'(rd_err), 32'd0);
            chk($sformatf("wrap%0d data", i), 32'(rd_data), 32'(8'(i + 8'h40)));
            chk($sformatf("wrap%0d level", i), 32'(rlevel), 32'd1);
            chk($sformatf("wrap%0d empty", i), 32'(rempty), 32'd0);
            chk($sformatf("wrap%0d rptr", i), 32'(rptr), 32'(gray(5'(i + 1))));
        end
        apb_rd_req = 1'b0;
        chk("wrap final rptr", 32'(rptr), 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
